// File: rtl/fbf_pkg.sv
// rtl/fbf_pkg.sv - shared block-datapath types, constants and helpers
package fbf_pkg;

    localparam int N      = 4;
    localparam int ELEM_W = 32;
    localparam int BLK_W  = N * N * ELEM_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } fbf_state_t;

    localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;
    localparam logic [31:0] FP32_PINF = 32'h7F80_0000;

    // Leading-zero count of the 27-bit aligned mantissa (hidden bit + 23 + G,R,S).
    function automatic logic [4:0] clz27(input logic [26:0] v);
        logic [4:0] n;
        logic       found;
        n     = 5'd27;
        found = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (!found && v[i]) begin
                n     = 5'(26 - i);
                found = 1'b1;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/fp32_add.sv
// rtl/fp32_add.sv - combinational binary32 adder, flush-to-zero, round-to-nearest-even
module fp32_add (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum
);
    import fbf_pkg::*;

    logic        sa, sb;
    logic [7:0]  ea, eb;
    logic [22:0] fa, fb;
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

    assign sa = a[31];
    assign sb = b[31];
    assign ea = a[30:23];
    assign eb = b[30:23];
    assign fa = a[22:0];
    assign fb = b[22:0];

    assign a_nan  = (ea == 8'hFF) && (fa != 23'd0);
    assign b_nan  = (eb == 8'hFF) && (fb != 23'd0);
    assign a_inf  = (ea == 8'hFF) && (fa == 23'd0);
    assign b_inf  = (eb == 8'hFF) && (fb == 23'd0);
    // Denormals count as zero, so only the exponent field matters here.
    assign a_zero = (ea == 8'd0);
    assign b_zero = (eb == 8'd0);

    // x is the larger magnitude; its sign is the sign of any nonzero result.
    logic        swap;
    logic        sx, sy;
    logic [7:0]  ex, ey, d;
    logic [26:0] x_ext, y_ext, y_al;

    assign swap  = {ea, fa} < {eb, fb};
    assign sx    = swap ? sb : sa;
    assign sy    = swap ? sa : sb;
    assign ex    = swap ? eb : ea;
    assign ey    = swap ? ea : eb;
    assign d     = ex - ey;
    assign x_ext = {1'b1, (swap ? fb : fa), 3'b000};
    assign y_ext = {1'b1, (swap ? fa : fb), 3'b000};

    always_comb begin
        y_al = 27'd1;
        if (d < 8'd27) begin
            y_al = y_ext >> d;
            if ((y_ext << (5'd27 - d[4:0])) != 27'd0)
                y_al[0] = 1'b1;
        end
    end

    logic        eff_sub;
    logic [27:0] s_add;
    logic [26:0] s_sub;

    assign eff_sub = sx ^ sy;
    assign s_add   = {1'b0, x_ext} + {1'b0, y_al};
    assign s_sub   = x_ext - y_al;

    logic [4:0]        lz;
    logic [26:0]       n;
    logic signed [9:0] en;

    always_comb begin
        lz = clz27(s_sub);
        n  = s_add[26:0];
        en = $signed({2'b00, ex});
        if (!eff_sub) begin
            if (s_add[27]) begin
                n  = s_add[27:1] | {26'd0, s_add[0]};
                en = $signed({2'b00, ex}) + 10'sd1;
            end
        end else begin
            n  = s_sub << lz;
            en = $signed({2'b00, ex}) - $signed({5'd0, lz});
        end
    end

    logic              rnd_up;
    logic [24:0]       m25;
    logic signed [9:0] e_r;

    assign rnd_up = n[2] & (n[1] | n[0] | n[3]);
    assign m25    = {1'b0, n[26:3]} + {24'd0, rnd_up};
    assign e_r    = en + $signed({9'd0, m25[24]});

    always_comb begin
        if (a_nan || b_nan)
            sum = FP32_QNAN;
        else if (a_inf && b_inf)
            sum = (sa != sb) ? FP32_QNAN : {sa, FP32_PINF[30:0]};
        else if (a_inf)
            sum = {sa, FP32_PINF[30:0]};
        else if (b_inf)
            sum = {sb, FP32_PINF[30:0]};
        else if (a_zero && b_zero)
            sum = {sa & sb, 31'd0};
        else if (a_zero)
            sum = b;
        else if (b_zero)
            sum = a;
        else if (eff_sub && (s_sub == 27'd0))
            sum = 32'd0;
        else if (en < 10'sd1)
            sum = 32'd0;
        else if (e_r >= 10'sd255)
            sum = {sx, FP32_PINF[30:0]};
        else
            sum = {sx, e_r[7:0], m25[22:0]};
    end

endmodule

// File: rtl/fbf_adder_v2.sv
// rtl/fbf_adder_v2.sv - 4x4 fp32 block adder iterating one shared fp32_add over 16 lanes
module fbf_adder_v2 #(
    parameter int N      = 4,
    parameter int ELEM_W = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     A_stb,
    input  logic                     B_stb,
    input  logic                     result_ack,
    input  logic [N*N*ELEM_W-1:0]    A,
    input  logic [N*N*ELEM_W-1:0]    B,
    output logic                     result_ready,
    output logic [N*N*ELEM_W-1:0]    result
);
    import fbf_pkg::fbf_state_t;
    import fbf_pkg::S_IDLE;
    import fbf_pkg::S_ADD;
    import fbf_pkg::S_DONE;

    localparam int LANES  = N * N;
    localparam int LANE_W = $clog2(LANES);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

    fbf_state_t               state;
    logic [LANE_W-1:0]        k;
    logic [N*N*ELEM_W-1:0]    op_a, op_b;
    logic [ELEM_W-1:0]        lane_a, lane_b, lane_sum;

    assign lane_a = op_a[k*ELEM_W +: ELEM_W];
    assign lane_b = op_b[k*ELEM_W +: ELEM_W];

    fp32_add u_add (
        .a   (lane_a),
        .b   (lane_b),
        .sum (lane_sum)
    );

    // Operands are captured once so the producer may move on while lanes iterate.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            k            <= '0;
            op_a         <= '0;
            op_b         <= '0;
            result       <= '0;
            result_ready <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (A_stb && B_stb) begin
                        op_a  <= A;
                        op_b  <= B;
                        k     <= '0;
                        state <= S_ADD;
                    end
                end
                S_ADD: begin
                    result[k*ELEM_W +: ELEM_W] <= lane_sum;
                    k <= k + 1'b1;
                    if (k == LAST_LANE)
                        state <= S_DONE;
                end
                S_DONE: begin
                    if (result_ready && result_ack) begin
                        result_ready <= 1'b0;
                        state        <= S_IDLE;
                    end else begin
                        result_ready <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fbf_adder_v2.sv
// tb/tb_fbf_adder_v2.sv - randomized and directed bench for fbf_adder_v2 against an exact-arithmetic model
module tb_fbf_adder_v2;

    logic         clk = 1'b0;
    logic         reset, A_stb, B_stb, result_ack;
    logic [511:0] A, B, result;
    logic         result_ready;
    int           checks = 0;
    int           failures = 0;

    always #5 clk = ~clk;

    fbf_adder_v2 dut (
        .clk          (clk),
        .reset        (reset),
        .A_stb        (A_stb),
        .B_stb        (B_stb),
        .result_ack   (result_ack),
        .A            (A),
        .B            (B),
        .result_ready (result_ready),
        .result       (result)
    );

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Exact sum on wide integers, then a single round-to-nearest-even.
    function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
        logic         sa, sb, rs, up;
        int           ea, eb, emin, p, e, sh;
        logic [23:0]  ma, mb;
        logic [299:0] xa, xb, mag, top, rem, half;
        sa = a[31]; sb = b[31];
        ea = int'(a[30:23]); eb = int'(b[30:23]);
        if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0)) return 32'h7FC00000;
        if (ea == 255 && eb == 255) return (sa != sb) ? 32'h7FC00000 : a;
        if (ea == 255) return a;
        if (eb == 255) return b;
        ma = (ea == 0) ? 24'd0 : {1'b1, a[22:0]};
        mb = (eb == 0) ? 24'd0 : {1'b1, b[22:0]};
        if (ea == 0) ea = 1;
        if (eb == 0) eb = 1;
        emin = (ea < eb) ? ea : eb;
        xa = 300'(ma) << (ea - emin);
        xb = 300'(mb) << (eb - emin);
        if (sa == sb) begin mag = xa + xb; rs = sa; end
        else if (xa >= xb) begin mag = xa - xb; rs = sa; end
        else begin mag = xb - xa; rs = sb; end
        if (mag == 0) return (sa && sb) ? 32'h80000000 : 32'h0;
        p = 0;
        for (int i = 0; i < 300; i++) if (mag[i]) p = i;
        e = p + emin - 23;
        up = 1'b0;
        if (p >= 24) begin
            sh   = p - 23;
            top  = mag >> sh;
            rem  = mag - (top << sh);
            half = 300'd1 << (sh - 1);
            up   = (rem > half) || (rem == half && top[0]);
        end else begin
            top = mag << (23 - p);
        end
        top = top + 300'(up);
        if (top[24]) begin top = top >> 1; e = e + 1; end
        if (e >= 255) return rs ? 32'hFF800000 : 32'h7F800000;
        if (e <= 0) return 32'h0;
        return {rs, 8'(e), top[22:0]};
    endfunction

    function automatic logic [511:0] ref_block(input logic [511:0] a, input logic [511:0] b);
        logic [511:0] r;
        for (int k = 0; k < 16; k++) r[k*32 +: 32] = ref_add(a[k*32 +: 32], b[k*32 +: 32]);
        return r;
    endfunction

    function automatic logic [31:0] int_to_fp(input int k);
        int          p;
        logic [31:0] m;
        if (k == 0) return 32'h0;
        p = 0;
        for (int i = 0; i < 31; i++) if (k[i]) p = i;
        m = 32'(k) << (23 - p);
        return {1'b0, 8'(127 + p), m[22:0]};
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [31:0] sp [9] = '{32'h0, 32'h80000000, 32'h7F800000, 32'hFF800000, 32'h7FC00000,
                                32'h7F7FFFFF, 32'h00000001, 32'h807FFFFF, 32'hFFA00001};
        logic [31:0] r;
        int          m;
        r = $urandom;
        m = $urandom_range(0, 9);
        if (m == 0) return r;
        if (m == 1) return sp[$urandom_range(0, 8)];
        if (m == 2) r[30:23] = 8'($urandom_range(248, 254));
        else r[30:23] = 8'($urandom_range(100, 154));
        return r;
    endfunction

    function automatic logic [31:0] rand_partner(input logic [31:0] a);
        logic [31:0] b;
        int          m, e;
        m = $urandom_range(0, 3);
        b = rand_fp();
        if (m == 1) b = {~a[31], a[30:6], a[5:0] ^ 6'($urandom)};
        if (m == 2 && a[30:23] > 8'd40 && a[30:23] < 8'd255) begin
            e = int'(a[30:23]) - $urandom_range(0, 30);
            b = {1'($urandom), 8'(e), 23'($urandom)};
        end
        return b;
    endfunction

    task automatic start_op(input logic [511:0] a, input logic [511:0] b);
        A = a; B = b; A_stb = 1'b1; B_stb = 1'b1;
        @(posedge clk); #1;
        A_stb = 1'b0; B_stb = 1'b0;
        A = ~a; B = ~b;
    endtask

    task automatic wait_ready(input string tag, input int exp_lat);
        int n;
        n = 0;
        while (!result_ready && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_lat"}, 512'(n), 512'(exp_lat));
    endtask

    task automatic do_ack(input string tag);
        result_ack = 1'b1;
        @(posedge clk); #1;
        result_ack = 1'b0;
        check({tag, "_ack"}, 512'(result_ready), 512'd0);
    endtask

    task automatic run_block(input string tag, input logic [511:0] a, input logic [511:0] b);
        logic [511:0] exp;
        exp = ref_block(a, b);
        start_op(a, b);
        wait_ready(tag, 17);
        check(tag, result, exp);
        do_ack(tag);
        check({tag, "_hold"}, result, exp);
    endtask

    logic [31:0]  da [9] = '{32'h3F800000, 32'h80000000, 32'h3F800000, 32'h3F800000, 32'h00000001,
                             32'h7F7FFFFF, 32'h7F800000, 32'h7FA00000, 32'hFF800000};
    logic [31:0]  db [9] = '{32'hBF800000, 32'h80000000, 32'h33800000, 32'h33C00000, 32'h00000000,
                             32'h7F7FFFFF, 32'hFF800000, 32'h3F800000, 32'h3F800000};
    logic [31:0]  de [9] = '{32'h00000000, 32'h80000000, 32'h3F800000, 32'h3F800001, 32'h00000000,
                             32'h7F800000, 32'h7FC00000, 32'h7FC00000, 32'hFF800000};

    initial begin
        logic [511:0] a, b, a2, b2, exp;
        reset = 1'b1; A_stb = 1'b0; B_stb = 1'b0; result_ack = 1'b0; A = '0; B = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 512'(result_ready), 512'd0);
        check("rst_result", result, 512'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        a = {16{32'h3F800000}};
        b = {16{32'h40000000}};
        start_op(a, b);
        wait_ready("basic", 17);
        check("basic", result, {16{32'h40400000}});
        do_ack("basic");

        for (int k = 0; k < 16; k++) a[k*32 +: 32] = int_to_fp(k);
        b = '0;
        run_block("lanes", a, b);
        check("lane0", 512'(result[0 +: 32]), 512'(32'h00000000));
        check("lane5", 512'(result[160 +: 32]), 512'(32'h40A00000));
        check("lane15", 512'(result[480 +: 32]), 512'(32'h41700000));

        for (int k = 0; k < 16; k++) begin
            a[k*32 +: 32] = (k < 9) ? da[k] : rand_fp();
            b[k*32 +: 32] = (k < 9) ? db[k] : rand_partner(a[k*32 +: 32]);
        end
        run_block("directed", a, b);
        for (int k = 0; k < 9; k++)
            check($sformatf("dir%0d", k), 512'(result[k*32 +: 32]), 512'(de[k]));

        for (int t = 0; t < 10; t++) begin
            for (int k = 0; k < 16; k++) begin
                a[k*32 +: 32] = rand_fp();
                b[k*32 +: 32] = rand_partner(a[k*32 +: 32]);
            end
            run_block($sformatf("rand%0d", t), a, b);
        end

        a = {16{32'h40800000}};
        b = {16{32'h3F800000}};
        start_op(a, b);
        repeat (8) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midrst_ready", 512'(result_ready), 512'd0);
        check("midrst_result", result, 512'd0);
        repeat (20) @(posedge clk);
        #1;
        check("midrst_idle", 512'(result_ready), 512'd0);

        A_stb = 1'b1;
        repeat (25) @(posedge clk);
        #1;
        check("astb_only", 512'(result_ready), 512'd0);
        A_stb = 1'b0;
        B_stb = 1'b1;
        repeat (25) @(posedge clk);
        #1;
        check("bstb_only", 512'(result_ready), 512'd0);
        B_stb = 1'b0;

        for (int k = 0; k < 16; k++) begin
            a[k*32 +: 32] = rand_fp();
            b[k*32 +: 32] = rand_partner(a[k*32 +: 32]);
        end
        exp = ref_block(a, b);
        start_op(a, b);
        result_ack = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        result_ack = 1'b0;
        wait_ready("early_ack", 12);
        check("early_ack", result, exp);
        repeat (3) @(posedge clk);
        #1;
        check("early_ack_held", 512'(result_ready), 512'd1);
        do_ack("early_ack");

        for (int k = 0; k < 16; k++) begin
            a[k*32 +: 32]  = rand_fp();
            b[k*32 +: 32]  = rand_partner(a[k*32 +: 32]);
            a2[k*32 +: 32] = rand_fp();
            b2[k*32 +: 32] = rand_partner(a2[k*32 +: 32]);
        end
        A = a; B = b; A_stb = 1'b1; B_stb = 1'b1;
        @(posedge clk); #1;
        A = a2; B = b2;
        wait_ready("b2b_first", 17);
        check("b2b_first", result, ref_block(a, b));
        do_ack("b2b_first");
        @(posedge clk); #1;
        A_stb = 1'b0; B_stb = 1'b0;
        A = '0; B = '0;
        wait_ready("b2b_second", 17);
        check("b2b_second", result, ref_block(a2, b2));
        do_ack("b2b_second");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
